// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus UART transmit port shared by uart_tx_arbiter and its users.
// The slave modport is the arbiter's view.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        txrdy;
  logic        tx_wen;
  logic [7:0]  tx_data;
  logic [3:0]  grant;
  logic        busy;

  modport master (
    output req_valid, req_data, req_last, txrdy,
    input  req_ready, tx_wen, tx_data, grant, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, txrdy,
    output req_ready, tx_wen, tx_data, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter that feeds whole packets, one byte at a time, into a UART
// transmit register. Each byte costs three cycles: accept, write strobe, hold-off.
module uart_tx_arbiter #(
  parameter int unsigned MAX_PKT      = 16,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [7:0] MaxPkt  = 8'(MAX_PKT);
  localparam logic [7:0] Timeout = 8'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSend, StStrobe, StHoldoff} state_e;

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic        release_q, release_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_wen_q, tx_wen_d;

  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        found;
  logic [7:0]  byte_inc;
  logic [7:0]  stall_inc;

  // Round-robin search upward from the requester after the last owner.
  always_comb begin
    win_idx = last_q;
    cand    = last_q;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && bus.req_valid[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= 4'b0000;
      gidx_q      <= 2'd0;
      last_q      <= 2'd3;
      byte_cnt_q  <= 8'd0;
      stall_cnt_q <= 8'd0;
      release_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_wen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      byte_cnt_q  <= byte_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      release_q   <= release_d;
      tx_data_q   <= tx_data_d;
      tx_wen_q    <= tx_wen_d;
    end
  end

  assign byte_inc  = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
  assign stall_inc = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    byte_cnt_d  = byte_cnt_q;
    stall_cnt_d = stall_cnt_q;
    release_d   = release_q;
    tx_data_d   = tx_data_q;
    tx_wen_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          grant_d     = 4'b0001 << win_idx;
          gidx_d      = win_idx;
          byte_cnt_d  = 8'd0;
          stall_cnt_d = 8'd0;
          release_d   = 1'b0;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (bus.req_valid[gidx_q] && bus.txrdy) begin
          tx_data_d   = bus.req_data[{gidx_q, 3'b000} +: 8];
          tx_wen_d    = 1'b1;
          stall_cnt_d = 8'd0;
          byte_cnt_d  = byte_inc;
          release_d   = bus.req_last[gidx_q] || (byte_inc >= MaxPkt);
          state_d     = StStrobe;
        end else if (!bus.req_valid[gidx_q]) begin
          // Back-pressure with valid held high never counts as a stall.
          if (stall_inc >= Timeout) begin
            state_d     = StIdle;
            grant_d     = 4'b0000;
            last_d      = gidx_q;
            stall_cnt_d = 8'd0;
          end else begin
            stall_cnt_d = stall_inc;
          end
        end
      end
      StStrobe: state_d = StHoldoff;
      StHoldoff: begin
        if (release_q) begin
          state_d = StIdle;
          grant_d = 4'b0000;
          last_d  = gidx_q;
        end else begin
          state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == StSend) ? (grant_q & {4{bus.txrdy}}) : 4'b0000;
    bus.busy      = (state_q != StIdle);
    bus.grant     = grant_q;
    bus.tx_wen    = tx_wen_q;
    bus.tx_data   = tx_data_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (MAX_PKT=4, IDLE_TIMEOUT=8): directed scenarios plus
// randomized packets compared against a packet-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int MaxPkt = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.MAX_PKT(4), .IDLE_TIMEOUT(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // Requester agents: byte i of requester r is mem[r][i] = {last, data}.
  logic [8:0]  mem [4][64];
  int          len [4];
  int          pos [4];
  bit          en [4];
  int          txrdy_mode;
  logic [3:0]  acc;
  logic [3:0]  stray;
  logic [3:0]  rdy_seen;
  logic [3:0]  gr_q [$];
  logic [11:0] ev_d [$];
  int          ev_c [$];
  logic [11:0] exp_q [$];

  task automatic apply_inputs();
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    v = '0; d = '0; l = '0;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && pos[i] < len[i]) begin
        v[i]        = 1'b1;
        d[i*8 +: 8] = mem[i][pos[i]][7:0];
        l[i]        = mem[i][pos[i]][8];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    case (txrdy_mode)
      0:       bus.txrdy = 1'b0;
      1:       bus.txrdy = 1'b1;
      default: bus.txrdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: drive, sample handshake mid-cycle, then observe registered outputs after the edge.
  task automatic step();
    apply_inputs();
    @(negedge clk);
    acc      = bus.req_valid & bus.req_ready & {4{reset_n}};
    stray    = stray | (bus.req_ready & ~bus.grant);
    rdy_seen = rdy_seen | bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) pos[i]++;
    gr_q.push_back(bus.grant);
    if (bus.tx_wen === 1'b1) begin
      ev_d.push_back({bus.grant, bus.tx_data});
      ev_c.push_back(gr_q.size() - 1);
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int n, input int budget);
    int b;
    b = budget;
    while (ev_d.size() < n && b > 0) begin
      step();
      b--;
    end
  endtask

  task automatic clear_agents();
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
      en[i]  = 1'b1;
    end
    acc = '0; stray = '0; rdy_seen = '0;
    gr_q.delete(); ev_d.delete(); ev_c.delete();
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input logic last);
    mem[r][len[r]] = {last, b};
    len[r]++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    txrdy_mode = 0;
    clear_agents();
    step_n(2);
    reset_n = 1'b1;
    clear_agents();
  endtask

  // Packet-level model: whole packets, split at MaxPkt, owners chosen round-robin after reset.
  task automatic build_model();
    int mp [4];
    int last, left, c, cand, n;
    bit done, hit;
    exp_q.delete();
    left = 0;
    for (int i = 0; i < 4; i++) begin
      mp[i] = 0;
      left += len[i];
    end
    last = 3;
    while (left > 0) begin
      c = last;
      hit = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        cand = (last + k) % 4;
        if (!hit && mp[cand] < len[cand]) begin
          c = cand;
          hit = 1'b1;
        end
      end
      n = 0;
      done = 1'b0;
      while (!done) begin
        exp_q.push_back({4'b0001 << c, mem[c][mp[c]][7:0]});
        done = mem[c][mp[c]][8] || (n + 1 == MaxPkt);
        mp[c]++;
        n++;
        left--;
      end
      last = c;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_agents();
    txrdy_mode = 1;
    add_byte(0, 8'h5A, 1'b1);
    step_n(3);
    total++; if (bus.tx_wen !== 1'b0) begin bad++; $display("FAIL reset_tx_wen: got %b want 0", bus.tx_wen); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    reset_n = 1'b1;
    clear_agents();
  endtask

  task automatic test_basic();
    logic [11:0] want;
    do_reset();
    txrdy_mode = 1;
    add_byte(0, 8'h41, 1'b0);
    add_byte(0, 8'h42, 1'b0);
    add_byte(0, 8'h43, 1'b1);
    run_until(3, 40);
    step_n(6);
    total++; if (ev_d.size() !== 3) begin bad++; $display("FAIL basic_count: got %0d want 3", ev_d.size()); end
    for (int k = 0; k < 3 && k < ev_d.size(); k++) begin
      want = {4'b0001, 8'h41 + 8'(k)};
      total++; if (ev_d[k] !== want) begin bad++; $display("FAIL basic_byte%0d: got %h want %h", k, ev_d[k], want); end
    end
    for (int k = 1; k < ev_c.size(); k++) begin
      total++; if (ev_c[k] - ev_c[k-1] !== 3) begin bad++; $display("FAIL basic_spacing%0d: got %0d want 3", k, ev_c[k] - ev_c[k-1]); end
    end
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL basic_grant_end: got %b want 0000", bus.grant); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [11:0] want [5];
    want[0] = {4'b0001, 8'hA0}; want[1] = {4'b0001, 8'hA1};
    want[2] = {4'b0100, 8'hC0}; want[3] = {4'b0100, 8'hC1};
    want[4] = {4'b0001, 8'hB0};
    do_reset();
    txrdy_mode = 1;
    add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hA1, 1'b1); add_byte(0, 8'hB0, 1'b1);
    add_byte(2, 8'hC0, 1'b0); add_byte(2, 8'hC1, 1'b1);
    run_until(5, 80);
    step_n(6);
    total++; if (ev_d.size() !== 5) begin bad++; $display("FAIL rr_count: got %0d want 5", ev_d.size()); end
    for (int k = 0; k < 5 && k < ev_d.size(); k++) begin
      total++; if (ev_d[k] !== want[k]) begin bad++; $display("FAIL rr_order%0d: got %h want %h", k, ev_d[k], want[k]); end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    do_reset();
    txrdy_mode = 0;
    add_byte(1, 8'h11, 1'b0); add_byte(1, 8'h12, 1'b1);
    step_n(2);
    rdy_seen = '0;
    step_n(20);
    total++; if (ev_d.size() !== 0) begin bad++; $display("FAIL bp_no_wen: got %0d want 0", ev_d.size()); end
    total++; if (rdy_seen !== 4'b0000) begin bad++; $display("FAIL bp_ready: got %b want 0000", rdy_seen); end
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL bp_grant_held: got %b want 0010", bus.grant); end
    c0 = gr_q.size() - 1;
    txrdy_mode = 1;
    run_until(1, 5);
    total++;
    if (ev_d.size() < 1 || ev_c[0] - c0 > 2) begin
      bad++; $display("FAIL bp_latency: got %0d want <=2", (ev_d.size() < 1) ? -1 : ev_c[0] - c0);
    end
    run_until(2, 20);
    total++; if (ev_d.size() !== 2 || ev_d[1] !== {4'b0010, 8'h12}) begin
      bad++; $display("FAIL bp_second: got %h want %h", (ev_d.size() > 1) ? ev_d[1] : 12'h0, {4'b0010, 8'h12});
    end
  endtask

  task automatic test_max_pkt();
    logic [11:0] want [8];
    for (int k = 0; k < 4; k++) want[k] = {4'b1000, 8'hD0 + 8'(k)};
    want[4] = {4'b0001, 8'hA0}; want[5] = {4'b0001, 8'hA1};
    want[6] = {4'b1000, 8'hD4}; want[7] = {4'b1000, 8'hD5};
    do_reset();
    txrdy_mode = 1;
    for (int k = 0; k < 6; k++) add_byte(3, 8'hD0 + 8'(k), k == 5);
    step_n(2);
    add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hA1, 1'b1);
    run_until(8, 100);
    step_n(6);
    total++; if (ev_d.size() !== 8) begin bad++; $display("FAIL maxpkt_count: got %0d want 8", ev_d.size()); end
    for (int k = 0; k < 8 && k < ev_d.size(); k++) begin
      total++; if (ev_d[k] !== want[k]) begin bad++; $display("FAIL maxpkt_order%0d: got %h want %h", k, ev_d[k], want[k]); end
    end
  endtask

  task automatic test_timeout();
    int e;
    do_reset();
    txrdy_mode = 1;
    add_byte(2, 8'h21, 1'b0);
    run_until(1, 10);
    total++;
    if (ev_d.size() !== 1) begin
      bad++; $display("FAIL to_first: got %0d want 1", ev_d.size());
    end else begin
      e = ev_c[0];
      add_byte(3, 8'h31, 1'b1);
      run_until(2, 40);
      step_n(2);
      total++; if (gr_q.size() <= e + 11 || gr_q[e+9] !== 4'b0100) begin
        bad++; $display("FAIL to_held: got %b want 0100", (gr_q.size() > e + 9) ? gr_q[e+9] : 4'hx);
      end
      total++; if (gr_q.size() <= e + 11 || gr_q[e+10] !== 4'b0000) begin
        bad++; $display("FAIL to_release: got %b want 0000", (gr_q.size() > e + 10) ? gr_q[e+10] : 4'hx);
      end
      total++; if (gr_q.size() <= e + 11 || gr_q[e+11] !== 4'b1000) begin
        bad++; $display("FAIL to_next_grant: got %b want 1000", (gr_q.size() > e + 11) ? gr_q[e+11] : 4'hx);
      end
      total++; if (ev_d.size() !== 2 || ev_d[1] !== {4'b1000, 8'h31}) begin
        bad++; $display("FAIL to_req3_byte: got %h want %h", (ev_d.size() > 1) ? ev_d[1] : 12'h0, {4'b1000, 8'h31});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    txrdy_mode = 1;
    add_byte(1, 8'h51, 1'b0); add_byte(1, 8'h52, 1'b0); add_byte(1, 8'h53, 1'b1);
    run_until(1, 20);
    total++; if (ev_d.size() !== 1) begin bad++; $display("FAIL rm_strobe: got %0d want 1", ev_d.size()); end
    reset_n = 1'b0;
    step();
    total++; if (bus.tx_wen !== 1'b0) begin bad++; $display("FAIL rm_tx_wen: got %b want 0", bus.tx_wen); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rm_tx_data: got %h want 00", bus.tx_data); end
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rm_grant: got %b want 0000", bus.grant); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rm_ready: got %b want 0000", bus.req_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    clear_agents();
    reset_n = 1'b1;
    step();
    total++; if (bus.busy !== 1'b0 || bus.tx_wen !== 1'b0) begin
      bad++; $display("FAIL rm_after_busy_wen: got %b%b want 00", bus.busy, bus.tx_wen);
    end
  endtask

  task automatic test_random();
    int npk, plen, nbytes;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      txrdy_mode = 2;
      nbytes = 0;
      for (int r = 0; r < 4; r++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          plen = $urandom_range(1, 6);
          for (int b = 0; b < plen; b++) add_byte(r, 8'($urandom), b == plen - 1);
          nbytes += plen;
        end
      end
      if (nbytes == 0) add_byte(1, 8'($urandom), 1'b1);
      build_model();
      run_until(exp_q.size(), 3000);
      step_n(8);
      total++; if (ev_d.size() !== exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count: got %0d want %0d", round, ev_d.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < ev_d.size(); k++) begin
        total++; if (ev_d[k] !== exp_q[k]) begin
          bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", round, k, ev_d[k], exp_q[k]);
        end
      end
      for (int k = 1; k < ev_c.size(); k++) begin
        total++; if (ev_c[k] - ev_c[k-1] < 3) begin
          bad++; $display("FAIL rand%0d_spacing%0d: got %0d want >=3", round, k, ev_c[k] - ev_c[k-1]);
        end
      end
      total++; if (stray !== 4'b0000) begin bad++; $display("FAIL rand%0d_stray_ready: got %b want 0000", round, stray); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rand%0d_idle_end: got %b want 0", round, bus.busy); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    txrdy_mode = 0;
    clear_agents();
    apply_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_max_pkt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_PKT, default 16: maximum bytes per grant before forced release; range 1..255.
REQ-002 Parameter IDLE_TIMEOUT, default 64: cycles a granted requester may hold valid low before its grant is revoked; range 1..255.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  4  per-requester byte valid.
REQ-006 req_data  in  32  requester i byte on [8i+7:8i].
REQ-007 req_last  in  4  per-requester end-of-packet flag, qualified by req_valid.
REQ-008 req_ready  out  4  per-requester byte accept.
REQ-009 txrdy  in  1  UART transmit-ready (hold register / FIFO has space).
REQ-010 tx_wen  out  1  one-cycle write strobe to UART transmit hold register / FIFO.
REQ-011 tx_data  out  8  byte to UART, valid while tx_wen=1.
REQ-012 grant  out  4  one-hot current owner; 0 when none.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, SEND, STROBE, HOLDOFF.
REQ-015 IDLE: if any req_valid=1, select a winner round-robin, searching upward from (last_grant+1) mod 4; register it into grant; go to SEND next cycle; otherwise stay.
REQ-016 last_grant SHALL update to the winner index when the grant is released, so the releasing requester has lowest priority at the next arbitration.
REQ-017 SEND: req_ready[g] SHALL equal txrdy for the granted index g (combinational); all other req_ready bits SHALL be 0 in every state.
REQ-018 A transfer occurs in cycle t when, in SEND, req_valid[g]=1 and req_ready[g]=1; the byte is registered into tx_data and the state goes to STROBE.
REQ-019 STROBE: tx_wen=1 for exactly this one cycle (t+1), with tx_data holding the transferred byte; then go to HOLDOFF.
REQ-020 HOLDOFF: one cycle, txrdy ignored, so txrdy is never sampled earlier than 2 cycles after a tx_wen; then go to SEND, or to IDLE if release is pending.
REQ-021 Release SHALL be pending after a transfer with req_last[g]=1, or when the 8-bit byte counter reaches MAX_PKT; on the IDLE entry grant SHALL be 0.
REQ-022 The byte counter SHALL clear on every grant and increment by 1 per transfer; it SHALL never wrap.
REQ-023 Packet lock: while granted, no other requester SHALL be served, even if the granted requester drops req_valid mid-packet.
REQ-024 In SEND with req_valid[g]=0, an 8-bit stall counter SHALL increment; at IDLE_TIMEOUT the grant is released (IDLE, grant=0, last_grant=g). The counter clears on any transfer or new grant.
REQ-025 Stall counting SHALL NOT occur while req_valid[g]=1 and txrdy=0 (back-pressure is not a timeout).
REQ-026 Minimum spacing between tx_wen pulses SHALL be 3 cycles; the maximum sustained rate is one byte per 3 cycles.
REQ-027 tx_data SHALL hold its last value outside STROBE; tx_wen SHALL be registered and glitch-free.

Reset
REQ-028 When reset_n=0 at a clock edge, the block SHALL enter IDLE with: tx_wen=0, tx_data=0x00, grant=0, req_ready=0, busy=0, counters=0, and last_grant=3 (requester 0 highest priority).
REQ-029 Reset SHALL take priority over all other inputs. A reset mid-packet SHALL abort without emitting a further tx_wen, and the first cycle after release SHALL be IDLE.

Verification
REQ-030 Reset, then req0 sends 0x41, 0x42, 0x43 (last on 0x43) with txrdy=1 -> exactly three tx_wen pulses carrying 0x41, 0x42, 0x43, 3 cycles apart; grant=0001 throughout; then grant=0000 and busy=0.
REQ-031 After reset, req0 and req2 both valid, each with a 2-byte packet -> both req0 bytes are sent before either req2 byte, with no interleave; then a new req0 packet is served only after req2 (round-robin).
REQ-032 Hold txrdy=0 for 20 cycles with req1 valid and granted -> no tx_wen, req_ready=0000, grant held; raise txrdy -> first tx_wen within 2 cycles.
REQ-033 MAX_PKT=4, req3 sends a 6-byte packet while req0 is pending -> 4 bytes from req3, then req0's packet, then req3's remaining 2 bytes.
REQ-034 IDLE_TIMEOUT=8, req2 granted, sends 1 byte, then drops valid -> grant goes to 0 exactly 8 cycles after entering SEND; pending req3 is then granted.
REQ-035 Assert reset_n=0 during STROBE of a multi-byte packet -> no tx_wen is emitted on the next cycle, and all outputs take their REQ-028 values.
